// File: rtl/decoder_pkg.sv
// Shared decoder control-word layout, used by both the packing and unpacking sides.
package decoder_pkg;

  localparam int unsigned AF_W    = 4;
  localparam int unsigned SHIFT_W = 3;
  localparam int unsigned REG_W   = 5;
  localparam int unsigned BF_W    = 4;
  localparam int unsigned PCSEL_W = 2;
  localparam int unsigned GPSEL_W = 2;

  localparam int unsigned CTRL_W = AF_W + 1 + 1 + SHIFT_W + REG_W + 1 + GPSEL_W +
                                   BF_W + PCSEL_W + 1 + 3 * REG_W;

  // Field order is MSB first; the unpacker splits the word in exactly this order.
  typedef struct packed {
    logic [AF_W-1:0]    af;
    logic               i;
    logic               alu_mux_sel;
    logic [SHIFT_W-1:0] shift_type;
    logic [REG_W-1:0]   cad;
    logic               gp_we;
    logic [GPSEL_W-1:0] gp_mux_sel;
    logic [BF_W-1:0]    bf;
    logic [PCSEL_W-1:0] pc_mux_select;
    logic               mem_wren;
    logic [REG_W-1:0]   rd;
    logic [REG_W-1:0]   rs;
    logic [REG_W-1:0]   rt;
  } ctrl_word_t;

  // All-zero: no GPR write, no memory write, sequential next PC.
  localparam logic [CTRL_W-1:0] CTRL_NOP = '0;

endpackage

// File: rtl/ctrl_skid_buffer.sv
// Two-entry skid buffer with valid/ready handshake, flush and occupancy.
// in_ready depends only on registered state and rst, never on out_ready.
module ctrl_skid_buffer #(
  parameter int unsigned     WIDTH          = 8,
  parameter logic [WIDTH-1:0] IDLE_WORD     = '0,
  parameter bit              ZERO_WHEN_IDLE = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [1:0]       occupancy
);

  logic             main_valid_q, main_valid_d;
  logic             skid_valid_q, skid_valid_d;
  logic [WIDTH-1:0] main_data_q, main_data_d;
  logic [WIDTH-1:0] skid_data_q, skid_data_d;
  logic             accept, consume;

  assign in_ready  = ~skid_valid_q & ~rst;
  assign accept    = in_valid & in_ready;
  assign consume   = main_valid_q & out_ready;
  assign out_valid = main_valid_q;
  assign occupancy = {1'b0, main_valid_q} + {1'b0, skid_valid_q};

  // Next-state: refill main from skid first, else from input; overflow lands in skid.
  always_comb begin
    main_valid_d = main_valid_q;
    skid_valid_d = skid_valid_q;
    main_data_d  = main_data_q;
    skid_data_d  = skid_data_q;
    if (flush) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (!main_valid_q || consume) begin
      if (skid_valid_q) begin
        main_valid_d = 1'b1;
        main_data_d  = skid_data_q;
        skid_valid_d = 1'b0;
      end else begin
        main_valid_d = accept;
        if (accept) main_data_d = in_data;
      end
    end else if (accept) begin
      skid_valid_d = 1'b1;
      skid_data_d  = in_data;
    end
  end

  // Valid bits carry all the state that matters, so only they are reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
    end else begin
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
    end
  end

  // Entry payloads, unreset.
  always_ff @(posedge clk) begin
    main_data_q <= main_data_d;
    skid_data_q <= skid_data_d;
  end

  // Mask stale payload with the idle word while nothing is valid.
  always_comb begin
    out_data = main_data_q;
    if (ZERO_WHEN_IDLE && !main_valid_q) out_data = IDLE_WORD;
  end

endmodule

// File: rtl/decoder_concat_stage.sv
// Packs the decoder control fields into the shared control word and buffers it
// through a skid stage toward the execute side.
module decoder_concat_stage
  import decoder_pkg::*;
#(
  parameter logic [CTRL_W-1:0] NOP_WORD       = CTRL_NOP,
  parameter bit                ZERO_WHEN_IDLE = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [AF_W-1:0]    af,
  input  logic               i,
  input  logic               alu_mux_sel,
  input  logic [SHIFT_W-1:0] shift_type,
  input  logic [REG_W-1:0]   cad,
  input  logic               gp_we,
  input  logic [GPSEL_W-1:0] gp_mux_sel,
  input  logic [BF_W-1:0]    bf,
  input  logic [PCSEL_W-1:0] pc_mux_select,
  input  logic               mem_wren,
  input  logic [REG_W-1:0]   rd,
  input  logic [REG_W-1:0]   rs,
  input  logic [REG_W-1:0]   rt,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               flush,
  output logic [CTRL_W-1:0]  packed_out,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [1:0]         occupancy
);

  ctrl_word_t word;

  // Field-to-struct packing; bit positions come from the shared struct layout.
  always_comb begin
    word               = '0;
    word.af            = af;
    word.i             = i;
    word.alu_mux_sel   = alu_mux_sel;
    word.shift_type    = shift_type;
    word.cad           = cad;
    word.gp_we         = gp_we;
    word.gp_mux_sel    = gp_mux_sel;
    word.bf            = bf;
    word.pc_mux_select = pc_mux_select;
    word.mem_wren      = mem_wren;
    word.rd            = rd;
    word.rs            = rs;
    word.rt            = rt;
  end

  ctrl_skid_buffer #(
    .WIDTH          (CTRL_W),
    .IDLE_WORD      (NOP_WORD),
    .ZERO_WHEN_IDLE (ZERO_WHEN_IDLE)
  ) u_skid (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_data   (word),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (packed_out),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .occupancy (occupancy)
  );

endmodule

// File: tb/tb_decoder_concat_stage.sv
// Directed bench for decoder_concat_stage: field mapping, streaming,
// back-pressure, flush and mid-stream reset.
module tb_decoder_concat_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  af;
  logic        i;
  logic        alu_mux_sel;
  logic [2:0]  shift_type;
  logic [4:0]  cad;
  logic        gp_we;
  logic [1:0]  gp_mux_sel;
  logic [3:0]  bf;
  logic [1:0]  pc_mux_select;
  logic        mem_wren;
  logic [4:0]  rd, rs, rt;
  logic        in_valid;
  logic        in_ready;
  logic        flush;
  logic [38:0] packed_out;
  logic        out_valid;
  logic        out_ready;
  logic [1:0]  occupancy;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  decoder_concat_stage dut (
    .clk           (clk),
    .rst           (rst),
    .af            (af),
    .i             (i),
    .alu_mux_sel   (alu_mux_sel),
    .shift_type    (shift_type),
    .cad           (cad),
    .gp_we         (gp_we),
    .gp_mux_sel    (gp_mux_sel),
    .bf            (bf),
    .pc_mux_select (pc_mux_select),
    .mem_wren      (mem_wren),
    .rd            (rd),
    .rs            (rs),
    .rt            (rt),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .flush         (flush),
    .packed_out    (packed_out),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .occupancy     (occupancy)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  task automatic clr_fields();
    af = '0; i = 1'b0; alu_mux_sel = 1'b0; shift_type = '0; cad = '0; gp_we = 1'b0;
    gp_mux_sel = '0; bf = '0; pc_mux_select = '0; mem_wren = 1'b0;
    rd = '0; rs = '0; rt = '0;
  endtask

  // Advance one clock and settle just after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Set exactly one packed-word bit via the field that owns it.
  task automatic drive_bit(input int pos);
    clr_fields();
    if (pos >= 35)      af            = 4'd1 << (pos - 35);
    else if (pos == 34) i             = 1'b1;
    else if (pos == 33) alu_mux_sel   = 1'b1;
    else if (pos >= 30) shift_type    = 3'd1 << (pos - 30);
    else if (pos >= 25) cad           = 5'd1 << (pos - 25);
    else if (pos == 24) gp_we         = 1'b1;
    else if (pos >= 22) gp_mux_sel    = 2'd1 << (pos - 22);
    else if (pos >= 18) bf            = 4'd1 << (pos - 18);
    else if (pos >= 16) pc_mux_select = 2'd1 << (pos - 16);
    else if (pos == 15) mem_wren      = 1'b1;
    else if (pos >= 10) rd            = 5'd1 << (pos - 10);
    else if (pos >= 5)  rs            = 5'd1 << (pos - 5);
    else                rt            = 5'd1 << pos;
  endtask

  logic [38:0] exp_w;

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    clr_fields();
    step();
    step();
    // Reset state
    check("rst_in_ready", 64'(in_ready), 64'(0));
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_occ", 64'(occupancy), 64'(0));
    check("rst_packed", 64'(packed_out), 64'(0));
    rst = 1'b0;
    #1;
    check("rel_in_ready", 64'(in_ready), 64'(1));

    // Field mapping
    out_ready = 1'b1;
    af = 4'hA; i = 1'b1; shift_type = 3'b101; cad = 5'd17; gp_we = 1'b1; bf = 4'h3;
    pc_mux_select = 2'b10; rd = 5'd1; rs = 5'd2; rt = 5'd3; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    exp_w = 39'h50_0000_0000 | (39'd1 << 34) | (39'd5 << 30) | (39'd17 << 25) |
            (39'd1 << 24) | (39'd3 << 18) | (39'd2 << 16) | (39'd1 << 10) |
            (39'd2 << 5) | 39'd3;
    check("map_valid", 64'(out_valid), 64'(1));
    check("map_word", 64'(packed_out), 64'(exp_w));
    step();
    check("map_idle_valid", 64'(out_valid), 64'(0));
    check("map_idle_word", 64'(packed_out), 64'(0));

    // Walking one through every bit, back to back
    for (int pos = 0; pos < 39; pos++) begin
      drive_bit(pos);
      in_valid = 1'b1;
      step();
      exp_w = 39'd1 << pos;
      check($sformatf("walk_%0d", pos), 64'(packed_out), 64'(exp_w));
    end
    in_valid = 1'b0;
    clr_fields();
    step();
    check("walk_end_valid", 64'(out_valid), 64'(0));

    // Streaming 8 words
    for (int k = 0; k < 8; k++) begin
      rt = 5'(k);
      in_valid = 1'b1;
      step();
      check($sformatf("stream_valid_%0d", k), 64'(out_valid), 64'(1));
      check($sformatf("stream_rt_%0d", k), 64'(packed_out[4:0]), 64'(k));
      check($sformatf("stream_ready_%0d", k), 64'(in_ready), 64'(1));
      check($sformatf("stream_occ_%0d", k), 64'(occupancy), 64'(1));
    end
    in_valid = 1'b0;
    step();
    check("stream_end_valid", 64'(out_valid), 64'(0));

    // Back-pressure
    out_ready = 1'b0;
    rt = 5'd1; in_valid = 1'b1;
    step();
    check("bp_occ1", 64'(occupancy), 64'(1));
    check("bp_ready1", 64'(in_ready), 64'(1));
    rt = 5'd2;
    step();
    check("bp_occ2", 64'(occupancy), 64'(2));
    check("bp_ready2", 64'(in_ready), 64'(0));
    rt = 5'd3;
    step();
    check("bp_hold_occ", 64'(occupancy), 64'(2));
    check("bp_hold_ready", 64'(in_ready), 64'(0));
    check("bp_hold_rt", 64'(packed_out[4:0]), 64'(1));
    out_ready = 1'b1;
    step();
    check("bp_rt2", 64'(packed_out[4:0]), 64'(2));
    check("bp_ready_back", 64'(in_ready), 64'(1));
    check("bp_occ_drain", 64'(occupancy), 64'(1));
    step();
    check("bp_rt3", 64'(packed_out[4:0]), 64'(3));
    check("bp_rt3_valid", 64'(out_valid), 64'(1));
    in_valid = 1'b0;
    step();
    check("bp_end_valid", 64'(out_valid), 64'(0));

    // Flush with two buffered words and an incoming word
    out_ready = 1'b0;
    rt = 5'd4; in_valid = 1'b1;
    step();
    rt = 5'd5;
    step();
    check("fl_occ2", 64'(occupancy), 64'(2));
    rt = 5'd6; flush = 1'b1;
    step();
    flush = 1'b0; in_valid = 1'b0;
    check("fl_valid", 64'(out_valid), 64'(0));
    check("fl_occ", 64'(occupancy), 64'(0));
    check("fl_word", 64'(packed_out), 64'(0));
    step();
    check("fl_no_ghost", 64'(out_valid), 64'(0));

    // Flush drops a same-cycle accept
    rt = 5'd7; in_valid = 1'b1;
    step();
    check("fl2_occ1", 64'(occupancy), 64'(1));
    rt = 5'd8; flush = 1'b1;
    step();
    flush = 1'b0; in_valid = 1'b0;
    check("fl2_valid", 64'(out_valid), 64'(0));
    check("fl2_occ", 64'(occupancy), 64'(0));
    step();
    check("fl2_no_ghost", 64'(out_valid), 64'(0));

    // Reset mid-stream
    rt = 5'd9; in_valid = 1'b1;
    step();
    rt = 5'd10;
    step();
    check("rs_occ2", 64'(occupancy), 64'(2));
    in_valid = 1'b0; rst = 1'b1;
    #1;
    check("rs_ready_in_rst", 64'(in_ready), 64'(0));
    step();
    check("rs_valid", 64'(out_valid), 64'(0));
    check("rs_occ", 64'(occupancy), 64'(0));
    check("rs_ready_held", 64'(in_ready), 64'(0));
    check("rs_word", 64'(packed_out), 64'(0));
    rst = 1'b0;
    #1;
    check("rs_ready_rel", 64'(in_ready), 64'(1));
    rt = 5'd11; in_valid = 1'b1; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    check("rs_first_valid", 64'(out_valid), 64'(1));
    check("rs_first_rt", 64'(packed_out[4:0]), 64'(11));
    step();
    check("rs_end_valid", 64'(out_valid), 64'(0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
